// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//
// Bundles every non-clock/reset signal of the fetch queue:
//   - redirect / redirect_pc        : control-flow change from the back end
//   - imem_req_valid/ready/addr     : fetch request channel to instruction memory
//   - imem_rsp_valid/data           : one-cycle response pulse per accepted request
//   - inst_valid/ready/data/pc      : queue head offered to the decode stage
//
// Modports:
//   master : the fetch queue itself (drives requests and the queue head)
//   slave  : the surrounding system (memory, decode and redirect sources)
// ---------------------------------------------------------------------------
interface fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;

    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        input  redirect,
        input  redirect_pc,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch unit with a small instruction queue. Issues one word-
// aligned fetch at a time to instruction memory, stores {pc, instruction}
// pairs in a DEPTH-entry circular queue and presents the head to decode.
// A redirect flushes the queue and restarts fetching at the new address;
// a response belonging to a request issued before the redirect is dropped.
//
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : queue entries (2, 4 or 8)
//
// Ports:
//   clk  : sole clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : fetch_queue_if.master (redirect, imem request/response, queue head)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // IDLE : no request outstanding, may issue one
    // WAIT : one request outstanding, its response will be enqueued
    // DROP : one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_reg;
    logic [31:0]       fetch_pc_reg;
    logic [31:0]       req_pc_reg;
    logic              hold_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;

    // Queue storage: written on push, read through a registered head port
    logic [31:0]       data_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       head_data_reg;
    logic [31:0]       head_pc_reg;

    logic              req_valid;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              unused_redirect_lsb;

    // The two low bits of redirect_pc are discarded by word alignment
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    // hold_reg keeps the request channel quiet for one cycle after reset so a
    // response still in flight from before reset lands while nothing is
    // outstanding and is ignored.
    assign req_valid = (state_reg == IDLE) && !hold_reg && !rst && !bus.redirect
                       && (count_reg < CNT_W'(DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Only a WAIT-state response is enqueued; redirect overrides the push.
    assign push = (state_reg == WAIT) && bus.imem_rsp_valid && !bus.redirect && !rst;
    assign pop  = (count_reg != '0) && bus.inst_ready && !bus.redirect && !rst;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM, fetch PC and queue bookkeeping
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= {RESET_PC[31:2], 2'b00};
            req_pc_reg   <= {RESET_PC[31:2], 2'b00};
            hold_reg     <= 1'b1;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            hold_reg <= 1'b0;
            if (bus.redirect) begin
                fetch_pc_reg <= {bus.redirect_pc[31:2], 2'b00};
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                unique case (state_reg)
                    // A request accepted in the redirect cycle would belong
                    // to the old stream; req_valid is held low during redirect
                    // so this only matters if that gating is ever relaxed.
                    IDLE:    state_reg <= req_fire ? DROP : IDLE;
                    // A response arriving together with the redirect is
                    // already consumed, so nothing is left outstanding.
                    WAIT:    state_reg <= bus.imem_rsp_valid ? IDLE : DROP;
                    DROP:    state_reg <= bus.imem_rsp_valid ? IDLE : DROP;
                    default: state_reg <= IDLE;
                endcase
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        if (req_fire) begin
                            state_reg    <= WAIT;
                            req_pc_reg   <= fetch_pc_reg;
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_rsp_valid) begin
                            state_reg <= IDLE;
                        end
                    end
                    DROP: begin
                        if (bus.imem_rsp_valid) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase

                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                rd_ptr_reg <= rd_ptr_next;

                unique case ({push, pop})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage and registered head read
    // -----------------------------------------------------------------------
    // The head register always reloads from the slot rd_ptr_next will point
    // at. When that slot is the one being written this cycle (queue empty
    // after the pop), the incoming response is forwarded directly. While the
    // head is stalled the same slot is reread and no write can target it, so
    // inst_data/inst_pc stay stable.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= bus.imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
        end
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_data_reg <= bus.imem_rsp_data;
            head_pc_reg   <= req_pc_reg;
        end else begin
            head_data_reg <= data_mem[rd_ptr_next];
            head_pc_reg   <= pc_mem[rd_ptr_next];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_reg;
    assign bus.inst_valid     = (count_reg != '0);
    assign bus.inst_data      = head_data_reg;
    assign bus.inst_pc        = head_pc_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. Two instances run in lockstep from the same
// stimulus: dut_a with RESET_PC = 0 and dut_b with RESET_PC = FFFF_FFF8 to
// exercise address wrap. Each has its own memory responder that returns
// ~address after a programmable latency. Pops are recorded at the negative
// edge; all comparisons go through check().
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        inst_ready;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_data_a, rsp_data_b;

    fetch_queue_if bus_a ();
    fetch_queue_if bus_b ();

    assign bus_a.redirect       = redirect;
    assign bus_a.redirect_pc    = redirect_pc;
    assign bus_a.imem_req_ready = imem_req_ready;
    assign bus_a.inst_ready     = inst_ready;
    assign bus_a.imem_rsp_valid = rsp_valid_a;
    assign bus_a.imem_rsp_data  = rsp_data_a;

    assign bus_b.redirect       = redirect;
    assign bus_b.redirect_pc    = redirect_pc;
    assign bus_b.imem_req_ready = imem_req_ready;
    assign bus_b.inst_ready     = inst_ready;
    assign bus_b.imem_rsp_valid = rsp_valid_b;
    assign bus_b.imem_rsp_data  = rsp_data_b;

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int vectors_applied = 0;
    int miscompares     = 0;

    // Memory responder state
    int          lat;
    logic        acc_a, acc_b;
    logic [31:0] acc_addr_a, acc_addr_b;
    logic        pend_a, pend_b;
    int          cnt_a, cnt_b;
    logic [31:0] addr_a, addr_b;

    // Recorded pops
    logic [31:0] pc_a_q[$];
    logic [31:0] data_a_q[$];
    logic [31:0] pc_b_q[$];
    logic [31:0] data_b_q[$];

    logic [31:0] exp_b [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_step(input logic acc, input logic [31:0] acc_addr,
                            inout logic pend, inout int cnt, inout logic [31:0] addr,
                            output logic v, output logic [31:0] d);
        v = 1'b0;
        d = 32'h0;
        if (acc) begin
            pend = 1'b1;
            cnt  = lat;
            addr = acc_addr;
        end
        if (pend) begin
            if (cnt <= 1) begin
                v    = 1'b1;
                d    = ~addr;
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
    endtask

    // One clock: sample handshakes before the edge, update responders after.
    task automatic tick();
        logic        v;
        logic [31:0] d;
        @(negedge clk);
        acc_a      = bus_a.imem_req_valid && imem_req_ready;
        acc_addr_a = bus_a.imem_req_addr;
        acc_b      = bus_b.imem_req_valid && imem_req_ready;
        acc_addr_b = bus_b.imem_req_addr;
        if (bus_a.inst_valid && inst_ready) begin
            pc_a_q.push_back(bus_a.inst_pc);
            data_a_q.push_back(bus_a.inst_data);
            $display("[%0t] pop a pc=%h data=%h", $time, bus_a.inst_pc, bus_a.inst_data);
        end
        if (bus_b.inst_valid && inst_ready) begin
            pc_b_q.push_back(bus_b.inst_pc);
            data_b_q.push_back(bus_b.inst_data);
        end
        @(posedge clk);
        #1;
        mem_step(acc_a, acc_addr_a, pend_a, cnt_a, addr_a, v, d);
        rsp_valid_a = v;
        rsp_data_a  = d;
        mem_step(acc_b, acc_addr_b, pend_b, cnt_b, addr_b, v, d);
        rsp_valid_b = v;
        rsp_data_b  = d;
    endtask

    task automatic clear_q();
        pc_a_q.delete();
        data_a_q.delete();
        pc_b_q.delete();
        data_b_q.delete();
    endtask

    task automatic wait_pops(input int n, input string tag);
        int k = 0;
        while (pc_a_q.size() < n && k < 80) begin
            tick();
            k++;
        end
        check({tag, "_pop_count_reached"}, 32'(pc_a_q.size() >= n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k;
        logic found;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        rsp_valid_a = 1'b0; rsp_valid_b = 1'b0; rsp_data_a = 32'h0; rsp_data_b = 32'h0;
        pend_a = 1'b0; pend_b = 1'b0; cnt_a = 0; cnt_b = 0; addr_a = 32'h0; addr_b = 32'h0;

        // ---- Reset and first request timing ----
        tick();
        tick();
        #1;
        check("rst_req_valid",  32'(bus_a.imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(bus_a.inst_valid),     32'd0);
        rst = 1'b0;
        clear_q();
        #1;
        check("hold_req_valid",  32'(bus_a.imem_req_valid), 32'd0);
        check("hold_inst_valid", 32'(bus_a.inst_valid),     32'd0);
        tick();
        #1;
        check("first_req_valid",  32'(bus_a.imem_req_valid), 32'd1);
        check("first_req_addr",   bus_a.imem_req_addr, 32'h0000_0000);
        check("first_req_addr_b", bus_b.imem_req_addr, 32'hFFFF_FFF8);

        // ---- Streaming with 1-cycle latency; wrap on dut_b ----
        wait_pops(4, "stream");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_pc%0d", i),   pc_a_q[i],   32'(i * 4));
            check($sformatf("stream_data%0d", i), data_a_q[i], ~(32'(i * 4)));
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap_pc%0d", i),   pc_b_q[i],   exp_b[i]);
            check($sformatf("wrap_data%0d", i), data_b_q[i], ~exp_b[i]);
        end

        // ---- Back-pressure: queue fills to DEPTH, head retained ----
        redirect = 1'b1; redirect_pc = 32'h0000_0100; inst_ready = 1'b0;
        tick();
        redirect = 1'b0;
        clear_q();
        repeat (20) tick();
        #1;
        check("full_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        check("full_inst_valid", 32'(bus_a.inst_valid),    32'd1);
        check("full_head_pc",   bus_a.inst_pc,   32'h0000_0100);
        check("full_head_data", bus_a.inst_data, 32'hFFFF_FEFF);
        inst_ready = 1'b1;
        wait_pops(5, "drain");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_pc%0d", i), pc_a_q[i], 32'h0000_0100 + 32'(i * 4));
        end

        // ---- Request stall: address held while not accepted ----
        imem_req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        tick();
        clear_q();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_valid%0d", i), 32'(bus_a.imem_req_valid), 32'd1);
            check($sformatf("stall_addr%0d", i),  bus_a.imem_req_addr, 32'h0000_0200);
            tick();
        end
        imem_req_ready = 1'b1;
        wait_pops(1, "stall");
        check("stall_pop_pc", pc_a_q[0], 32'h0000_0200);

        // ---- Redirect while WAIT, response arrives later and is dropped ----
        lat = 3;
        k = 0;
        acc_a = 1'b0;
        while (!acc_a && k < 40) begin
            tick();
            k++;
        end
        check("drop_accept_seen", 32'(acc_a), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_1002;
        tick();
        redirect = 1'b0;
        clear_q();
        #1;
        check("drop_req_valid0", 32'(bus_a.imem_req_valid), 32'd0);
        tick();
        #1;
        check("drop_req_valid1", 32'(bus_a.imem_req_valid), 32'd0);
        tick();
        #1;
        check("refetch_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check("refetch_req_addr",  bus_a.imem_req_addr, 32'h0000_1000);
        wait_pops(2, "redirect");
        check("redirect_pc0",   pc_a_q[0],   32'h0000_1000);
        check("redirect_data0", data_a_q[0], 32'hFFFF_EFFF);
        check("redirect_pc1",   pc_a_q[1],   32'h0000_1004);

        // ---- Reset with 3 queued entries and a request outstanding ----
        lat = 2;
        inst_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        k = 0;
        found = 1'b0;
        while (!found && k < 60) begin
            tick();
            k++;
            if (acc_a && acc_addr_a == 32'h0000_030C) found = 1'b1;
        end
        check("rst_mid_accept_seen", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_q();
        #1;
        check("rst_mid_inst_valid", 32'(bus_a.inst_valid),     32'd0);
        check("rst_mid_req_valid",  32'(bus_a.imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        tick();
        #1;
        check("rst_mid_req_valid2", 32'(bus_a.imem_req_valid), 32'd1);
        check("rst_mid_req_addr",   bus_a.imem_req_addr, 32'h0000_0000);
        wait_pops(2, "rst_mid");
        check("rst_mid_pc0",   pc_a_q[0],   32'h0000_0000);
        check("rst_mid_data0", data_a_q[0], 32'hFFFF_FFFF);
        check("rst_mid_pc1",   pc_a_q[1],   32'h0000_0004);
        check("rst_mid_pc0_b", pc_b_q[0],   32'hFFFF_FFF8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
